alu_issue_arb: RTL and testbench
================================

# alu_issue_arb

Two-requester issue arbiter and pipeline sequencer for the shared integer ALU. It accepts operation requests from two clients, such as the execute stage and the branch/address unit, over valid/ready handshakes. It grants one request per cycle with round-robin fairness and drives the combinational ALU from registered operands. It returns the registered result, flags and requester ID over a single valid/ready response channel.

## Interface
- XLEN, 32: operand/result width; the ALU instance uses the same value.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; a transfer occurs when valid&ready.
- req_funct7  in  14  requester i at [7i+6:7i].
- req_funct3  in  6  requester i at [3i+2:3i].
- req_a  in  2*XLEN  operand A; requester i at [XLEN*i +: XLEN].
- req_b  in  2*XLEN  operand B; same packing as req_a.
- alu_funct7  out  7  to ALU; driven from the issue register.
- alu_funct3  out  3  to ALU.
- alu_a, alu_b  out  XLEN  to ALU.
- alu_result  in  XLEN  from ALU (combinational).
- alu_flags  in  4  from ALU, ordered {V,C,N,Z}.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  1  index of the requester that issued the response.
- rsp_result  out  XLEN  registered ALU result.
- rsp_flags  out  4  registered flags (see Configuration).

## Operation
- Two-stage pipeline:
  - S1 (issue register): valid bit, id, funct7, funct3, a, b. Drives the alu_* ports.
  - S2 (response register): valid bit, id, result, flags. Drives the rsp_* ports.
- Stall and accept conditions:
  - s2_free = !rsp_valid | rsp_ready.
  - s1_adv = s1_valid & s2_free.
  - s1_free = !s1_valid | s2_free.
- Arbitration:
  - pointer ptr (1 bit) names the priority requester.
  - If both requests are valid, grant = ptr.
  - If one is valid, grant = that one.
  - req_ready[i] = s1_free & grant[i]. At most one bit of req_ready is high per cycle.
  - ptr <= ~granted index on every accepted transfer; ptr is unchanged when nothing is accepted.
- On an accepted transfer, S1 loads the granted fields and s1_valid<=1.
  - Otherwise, if s1_adv, s1_valid<=0.
  - If S1 is stalled, it holds its contents.
- If s1_adv: S2 loads alu_result, alu_flags and the S1 id, and rsp_valid<=1.
  - Else if rsp_ready: rsp_valid<=0.
  - Otherwise S2 holds.
- Requesters hold all request fields stable while valid & !ready. The arbiter does not check this.
- Operands pass through unmodified. Opcode legality is not checked; every funct3/funct7 combination is forwarded.
- The alu_* ports are driven even when S1 is invalid (last loaded contents). Consumers must ignore them.

## Timing
- Reset (rst=1 at a clock edge):
  - s1_valid=0, rsp_valid=0, ptr=0.
  - All S1/S2 data registers = 0, so alu_* = 0, rsp_id=0, rsp_result=0, rsp_flags=0.
  - req_ready=0 during reset. Requests in flight are discarded, not replayed.
- Latency: a request accepted at edge N yields rsp_valid=1 after edge N+1, i.e. two cycles from the request cycle to response visibility.
- Throughput: one request per cycle with rsp_ready held high.
- Backpressure:
  - With rsp_ready=0, S2 and S1 fill; req_ready drops to 00 once both are valid.
  - No data is lost or duplicated. Full order is preserved; responses return in acceptance order.
- Simultaneous events:
  - Acceptance into S1 and advance out of S1 in the same cycle is allowed (full throughput).
  - rsp_ready and a new S2 load in the same cycle replace the entry; rsp_valid stays 1.

## Configuration
- ALU_ISSUE_ARB_FLAGS_EN defined: alu_flags is captured into S2 and presented on rsp_flags.
- ALU_ISSUE_ARB_FLAGS_EN undefined:
  - no flag register; rsp_flags is tied to 4'b0000.
  - alu_flags is unused.
  - All other behaviour is identical.

## Structure
- Shared package alu_pkg:
  - funct3 constants (ADD/SUB=000 … AND=111).
  - the funct7 SUB/SRA bit index 5.
  - a flag-index typedef {V=3,C=2,N=1,Z=0}.
- One sub-module, rr_arb2: 2-input round-robin picker with inputs req[1:0], ptr, and output gnt[1:0] (one-hot or zero). Its pointer register stays in the parent.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Reset then single request: req0 with funct3=000, funct7=0, a=5, b=7, rsp_ready=1.
  - req_ready=01 in cycle 0.
  - rsp_valid=1, rsp_id=0, rsp_result=12 two cycles later; with flags enabled, rsp_flags=0000.
- Contention: both requests held valid for 4 cycles, req1 doing SUB of 3-3.
  - Grants alternate 0,1,0,1 starting from requester 0 (ptr=0 after reset).
  - Requester 1's responses carry rsp_result=0 and, with flags enabled, Z=1, C=1.
- Backpressure: rsp_ready=0 while req0 issues 3 back-to-back adds.
  - Exactly two are accepted, then req_ready=00.
  - Raising rsp_ready returns all responses in order with no duplicates.
- Full throughput: 8 alternating requests with rsp_ready=1.
  - One response per cycle after a 2-cycle fill.
  - rsp_id sequence is 0,1,0,1,…
- Reset mid-flight: assert rst while S1 and S2 are valid.
  - The next cycle shows rsp_valid=0, req_ready=00, rsp_result=0.
  - After rst deasserts, the first grant goes to req0 when both requesters are valid.
- Flags compiled out: run the SUB 0x80000000-1 case (V=1).
  - rsp_flags=0000.
  - rsp_result=0x7FFFFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: funct3 opcodes, the funct7 alternate-op bit, and flag bit positions.
package alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;  // ADD, or SUB with funct7 alternate bit set
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;  // SRL, or SRA with funct7 alternate bit set
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam int F7_ALT_BIT = 5;

  typedef enum logic [1:0] {
    FLAG_Z = 2'd0,
    FLAG_N = 2'd1,
    FLAG_C = 2'd2,
    FLAG_V = 2'd3
  } flag_idx_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; ptr names the requester that wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
    else              gnt = req;
  end

endmodule

// File: rtl/alu_issue_arb.sv
// Two-requester round-robin issue arbiter with a two-stage ALU issue/response pipeline.
// Optional flag capture is enabled by defining ALU_ISSUE_ARB_FLAGS_EN.
module alu_issue_arb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [13:0]       req_funct7,
  input  logic [5:0]        req_funct3,
  input  logic [2*XLEN-1:0] req_a,
  input  logic [2*XLEN-1:0] req_b,
  output logic [6:0]        alu_funct7,
  output logic [2:0]        alu_funct3,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [XLEN-1:0]   rsp_result,
  output logic [3:0]        rsp_flags
);

  logic            ptr_q, ptr_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s1_id_q, s1_id_d;
  logic [6:0]      s1_f7_q, s1_f7_d;
  logic [2:0]      s1_f3_q, s1_f3_d;
  logic [XLEN-1:0] s1_a_q, s1_a_d;
  logic [XLEN-1:0] s1_b_q, s1_b_d;
  logic            s2_valid_q, s2_valid_d;
  logic            s2_id_q, s2_id_d;
  logic [XLEN-1:0] s2_res_q, s2_res_d;

  logic       s2_free, s1_adv, s1_free, accept, gidx;
  logic [1:0] gnt;

  rr_arb2 u_rr_arb2 (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign s2_free = !s2_valid_q || rsp_ready;
  assign s1_adv  = s1_valid_q && s2_free;
  assign s1_free = !s1_valid_q || s2_free;

  // Ready is forced low while reset is held so nothing is accepted into a clearing pipe.
  assign req_ready = (rst || !s1_free) ? 2'b00 : gnt;
  assign accept    = |(req_valid & req_ready);
  assign gidx      = gnt[1];

  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_f7_d    = s1_f7_q;
    s1_f3_d    = s1_f3_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (accept) begin
      ptr_d      = ~gidx;
      s1_valid_d = 1'b1;
      s1_id_d    = gidx;
      s1_f7_d    = req_funct7[7*gidx +: 7];
      s1_f3_d    = req_funct3[3*gidx +: 3];
      s1_a_d     = req_a[XLEN*gidx +: XLEN];
      s1_b_d     = req_b[XLEN*gidx +: XLEN];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_res_d   = s2_res_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_id_d    = s1_id_q;
      s2_res_d   = alu_result;
    end else if (rsp_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s1_f7_q    <= '0;
      s1_f3_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_f7_q    <= s1_f7_d;
      s1_f3_q    <= s1_f3_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_res_q   <= s2_res_d;
    end
  end

`ifdef ALU_ISSUE_ARB_FLAGS_EN
  logic [3:0] s2_flags_q, s2_flags_d;

  always_comb begin
    s2_flags_d = s2_flags_q;
    if (s1_adv) s2_flags_d = alu_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) s2_flags_q <= '0;
    else     s2_flags_q <= s2_flags_d;
  end

  assign rsp_flags = s2_flags_q;
`else
  logic unused_alu_flags;
  assign unused_alu_flags = ^alu_flags;
  assign rsp_flags        = 4'b0000;
`endif

  assign alu_funct7 = s1_f7_q;
  assign alu_funct3 = s1_f3_q;
  assign alu_a      = s1_a_q;
  assign alu_b      = s1_b_q;

  assign rsp_valid  = s2_valid_q;
  assign rsp_id     = s2_id_q;
  assign rsp_result = s2_res_q;

endmodule

// File: tb/tb_alu_issue_arb.sv
// Directed self-checking bench for alu_issue_arb with a behavioural ALU model on the alu_* ports.
module tb_alu_issue_arb;

  localparam int XLEN = 32;
`ifdef ALU_ISSUE_ARB_FLAGS_EN
  localparam bit FL_EN = 1'b1;
`else
  localparam bit FL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [13:0]       req_funct7;
  logic [5:0]        req_funct3;
  logic [2*XLEN-1:0] req_a;
  logic [2*XLEN-1:0] req_b;
  logic [6:0]        alu_funct7;
  logic [2:0]        alu_funct3;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [XLEN-1:0]   alu_result;
  logic [3:0]        alu_flags;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [XLEN-1:0]   rsp_result;
  logic [3:0]        rsp_flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_arb #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct7 (req_funct7),
    .req_funct3 (req_funct3),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_funct7 (alu_funct7),
    .alu_funct3 (alu_funct3),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
  );

  // Behavioural ALU: ADD/SUB with {V,C,N,Z}, carry meaning "no borrow" on SUB.
  logic [XLEN:0]   m_sum;
  logic [XLEN-1:0] m_beff;
  logic [XLEN-1:0] m_res;
  logic [3:0]      m_fl;
  logic            m_sub;
  always_comb begin
    m_sum  = '0;
    m_beff = alu_b;
    m_res  = '0;
    m_fl   = '0;
    m_sub  = 1'b0;
    case (alu_funct3)
      3'b000: begin
        m_sub   = alu_funct7[5];
        m_beff  = m_sub ? ~alu_b : alu_b;
        m_sum   = {1'b0, alu_a} + {1'b0, m_beff} + {{XLEN{1'b0}}, m_sub};
        m_res   = m_sum[XLEN-1:0];
        m_fl[2] = m_sum[XLEN];
        m_fl[3] = (alu_a[XLEN-1] == m_beff[XLEN-1]) && (m_res[XLEN-1] != alu_a[XLEN-1]);
      end
      3'b111:  m_res = alu_a & alu_b;
      3'b110:  m_res = alu_a | alu_b;
      3'b100:  m_res = alu_a ^ alu_b;
      default: m_res = alu_a + alu_b;
    endcase
    m_fl[1] = m_res[XLEN-1];
    m_fl[0] = (m_res == '0);
    alu_result = m_res;
    alu_flags  = m_fl;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_funct7[7*i +: 7]    = f7;
    req_funct3[3*i +: 3]    = f3;
    req_a[XLEN*i +: XLEN]   = a;
    req_b[XLEN*i +: XLEN]   = b;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    set_req(0, 7'h00, 3'b000, 32'd9, 32'd9);
    set_req(1, 7'h00, 3'b000, 32'd1, 32'd1);
    step();
    step();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_rsp_result: got %0h expected 0", rsp_result); end
    checks++; if (rsp_id !== 1'b0 || rsp_flags !== 4'b0000) begin errors++; $display("FAIL reset_rsp_id_flags: got id=%b flags=%b expected 0 0000", rsp_id, rsp_flags); end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_funct3 !== 3'd0 || alu_funct7 !== 7'd0) begin errors++; $display("FAIL reset_alu_ports: got a=%0h b=%0h f3=%0h f7=%0h expected zeros", alu_a, alu_b, alu_funct3, alu_funct7); end
    req_valid = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_req(0, 7'h00, 3'b000, 32'd5, 32'd7);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    step();
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin errors++; $display("FAIL single_s1: got rsp_valid=%b a=%0d b=%0d expected 0 5 7", rsp_valid, alu_a, alu_b); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd12) begin errors++; $display("FAIL single_rsp: got v=%b id=%b res=%0d expected 1 0 12", rsp_valid, rsp_id, rsp_result); end
    checks++; if (rsp_flags !== 4'b0000) begin errors++; $display("FAIL single_flags: got %b expected 0000", rsp_flags); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_ready;
    apply_reset();
    set_req(0, 7'h00, 3'b000, 32'd10, 32'd20);
    set_req(1, 7'h20, 3'b000, 32'd3, 32'd3);
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 4) ? 2'b11 : 2'b00;
      #1;
      if (k < 4) begin
        exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL contention_grant[%0d]: got %b expected %b", k, req_ready, exp_ready); end
      end
      if (k >= 2) begin
        if ((k - 2) % 2 == 0) begin
          checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd30 || rsp_flags !== 4'b0000) begin errors++; $display("FAIL contention_rsp0[%0d]: got v=%b id=%b res=%0d fl=%b expected 1 0 30 0000", k, rsp_valid, rsp_id, rsp_result, rsp_flags); end
        end else begin
          checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd0 || rsp_flags !== (FL_EN ? 4'b0101 : 4'b0000)) begin errors++; $display("FAIL contention_rsp1[%0d]: got v=%b id=%b res=%0d fl=%b expected 1 1 0 %b", k, rsp_valid, rsp_id, rsp_result, rsp_flags, (FL_EN ? 4'b0101 : 4'b0000)); end
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    set_req(0, 7'h00, 3'b000, 32'd1, 32'd100);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept0: got %b expected 01", req_ready); end
    step();
    set_req(0, 7'h00, 3'b000, 32'd2, 32'd100);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept1: got %b expected 01", req_ready); end
    step();
    set_req(0, 7'h00, 3'b000, 32'd3, 32'd100);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_full[%0d]: got %b expected 00", k, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd101) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b res=%0d expected 1 101", k, rsp_valid, rsp_result); end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01 || rsp_result !== 32'd101) begin errors++; $display("FAIL bp_release: got ready=%b res=%0d expected 01 101", req_ready, rsp_result); end
    step();
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd102) begin errors++; $display("FAIL bp_rsp2: got v=%b res=%0d expected 1 102", rsp_valid, rsp_result); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd103) begin errors++; $display("FAIL bp_rsp3: got v=%b res=%0d expected 1 103", rsp_valid, rsp_result); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ready;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        set_req(k % 2, 7'h00, 3'b000, 32'(k * 10), 32'(k));
        req_valid = (k % 2 == 0) ? 2'b01 : 2'b10;
      end else begin
        req_valid = 2'b00;
      end
      #1;
      if (k < 8) begin
        exp_ready = req_valid;
        checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, req_ready, exp_ready); end
      end
      if (k >= 2) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'((k - 2) % 2) || rsp_result !== 32'(11 * (k - 2))) begin errors++; $display("FAIL b2b_rsp[%0d]: got v=%b id=%b res=%0d expected 1 %0d %0d", k, rsp_valid, rsp_id, rsp_result, (k - 2) % 2, 11 * (k - 2)); end
      end
      step();
    end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    rsp_ready = 1'b0;
    set_req(0, 7'h00, 3'b000, 32'd40, 32'd2);
    set_req(1, 7'h00, 3'b000, 32'd50, 32'd3);
    req_valid = 2'b01;
    step();
    step();
    checks++; if (rsp_valid !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL mid_prefill: got v=%b ready=%b expected 1 00", rsp_valid, req_ready); end
    rst = 1'b1;
    req_valid = 2'b11;
    step();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00 || rsp_result !== 32'd0) begin errors++; $display("FAIL mid_reset: got v=%b ready=%b res=%0d expected 0 00 0", rsp_valid, req_ready, rsp_result); end
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_first_grant: got %b expected 01", req_ready); end
    step();
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_replay: got %b expected 0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd42) begin errors++; $display("FAIL mid_rsp: got v=%b id=%b res=%0d expected 1 0 42", rsp_valid, rsp_id, rsp_result); end
    step();
  endtask

  task automatic test_flags_overflow();
    apply_reset();
    set_req(1, 7'h20, 3'b000, 32'h8000_0000, 32'h0000_0001);
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL ovf_ready: got %b expected 10", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ovf_result: got v=%b id=%b res=%0h expected 1 1 7fffffff", rsp_valid, rsp_id, rsp_result); end
    checks++; if (rsp_flags !== (FL_EN ? 4'b1100 : 4'b0000)) begin errors++; $display("FAIL ovf_flags: got %b expected %b", rsp_flags, (FL_EN ? 4'b1100 : 4'b0000)); end
    step();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b00;
    rsp_ready  = 1'b1;
    req_funct7 = '0;
    req_funct3 = '0;
    req_a      = '0;
    req_b      = '0;
    #1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_flags_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
